modulo_n_checker: RTL and testbench
===================================

# modulo_N_checker

Passive monitor for the `modulo_N` counter output. Samples a counter value on every enabled clock edge, checks that successive samples follow the modulo-N sequence 0, 1, …, N-1, 0, …, and reports lock, wrap and error status. Sits beside a `modulo_N` instance, in benches or in hardware as a self-check, driven by the same `clk` and `ce`.

## Interface

- `N`, 10: counter modulus; N ≥ 2.
- `WIDTH`, `$clog2(N)`: width of the monitored value.
- `LOCK_LEN`, 3: consecutive correct transitions required to declare lock; ≥ 1.
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ce`  in  1  sample enable; the same enable that drives the monitored counter.
- `cnt`  in  WIDTH  monitored counter value.
- `locked`  out  1  high while the sequence is tracked.
- `wrap`  out  1  one-cycle pulse on a correct N-1 → 0 transition while locked.
- `err`  out  1  one-cycle pulse on a detected violation while locked.
- `err_cnt`  out  ERR_W  saturating count of `err` pulses.

## Operation

- Internal state: `prev` (WIDTH, last sampled value), `good` (consecutive-good counter, width `$clog2(LOCK_LEN+1)`), FSM `state`.
- `exp = (prev == N-1) ? 0 : prev + 1`. Compare at WIDTH bits; no modular arithmetic beyond this.
- A sample is taken on an edge with `ce=1`. A sample with `cnt ≥ N` is **out of range**.
- IDLE: an in-range sample sets `prev=cnt` and `good=0`, then moves to ACQ. An out-of-range sample stays in IDLE.
- ACQ:
  - `cnt==exp`: `good+1`. When `good` reaches `LOCK_LEN`, move to LOCK.
  - In-range mismatch: `prev=cnt`, `good=0`, stay in ACQ, no `err`.
  - Out-of-range: go to IDLE.
  - `prev` updates to `cnt` on every in-range sample.
- LOCK:
  - `cnt==exp`: stay. Pulse `wrap` if `prev==N-1`.
  - In-range mismatch: pulse `err`, `prev=cnt`, `good=0`, go to ACQ.
  - Out-of-range: pulse `err`, go to IDLE.
- `locked = (state == LOCK)`.
- `err_cnt` increments on each `err` pulse and saturates at 2^ERR_W-1.
- `ce=0`: no sample; state, `prev` and `good` hold. See Configuration for the optional hold check.

## Timing

- Reset (`rst=0`) clears immediately, without waiting for a clock edge: state=IDLE, `prev=0`, `good=0`, `locked=0`, `wrap=0`, `err=0`, `err_cnt=0`. This also applies mid-operation.
- All outputs are registered. The response to the sample taken at edge k is visible from edge k until edge k+1.
- `wrap` and `err` last exactly one cycle and are never asserted together.
- From reset with a clean sequence, `locked` rises at the edge taking sample LOCK_LEN+1.
- Sampling at the same edge at which the counter updates is correct: the monitor sees the pre-increment value.

## Configuration

- `MODN_HOLD_CHECK_EN` defined: in LOCK, an edge with `ce=0` and `cnt != exp` is a violation.
  - The counter has already advanced, so `cnt` must show the next value.
  - Same response as an in-range mismatch: `err`, `err_cnt`+1, go to ACQ with `prev=cnt`.
- `MODN_HOLD_CHECK_EN` undefined: `cnt` is ignored when `ce=0`.

## Structure

- Shared package `modulo_n_pkg`:
  - state encoding: IDLE=2'd0, ACQ=2'd1, LOCK=2'd2; 2'd3 recovers to IDLE.
  - function `mod_next(prev, N)` computing `exp`, shared with the bench model.
- One natural sub-module, `sat_counter`: parameter `W`, inputs `clk`/`rst`/`inc`, saturating output. It implements `err_cnt`.

## Test plan

- N=10, LOCK_LEN=3: reset, then `ce=1`, `cnt`=0..9,0,1 → `locked`=1 from the edge sampling 3; `wrap`=1 only at the edge sampling 0 after 9; `err`=0 throughout.
- While locked, sample 5 where 4 is expected → `err` for 1 cycle, `err_cnt`=1, `locked`=0; then 6,7,8 → `locked`=1 at the edge sampling 8.
- While locked, `ce` pattern 1,0,0,1 with a real `modulo_N` driving `cnt` → no `err`, `locked` stays 1. With `MODN_HOLD_CHECK_EN`, forcing `cnt` to change during `ce=0` → `err`=1.
- While locked, `cnt`=12 → `err`=1, state IDLE, `locked`=0; a sample of 13 in IDLE → no `err`.
- ERR_W=2: four lock-then-error cycles → `err_cnt` 1,2,3,3 (saturates).
- Locked, `err_cnt`=2, drive `rst`=0 between clock edges → all outputs 0 immediately. Release, then a clean sequence → relock after four samples.

Source files
------------

// File: rtl/modulo_n_pkg.sv
// Shared types and helpers for the modulo-N sequence checker.
// Holds the FSM state encoding and the expected-next-value function.
package modulo_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    function automatic int unsigned mod_next(input int unsigned prev, input int unsigned n);
        return (prev == n - 1) ? 0 : prev + 1;
    endfunction

endpackage

// File: rtl/modulo_n_checker_sat_counter.sv
// Saturating up-counter; holds at all-ones once full.
// Used for the violation tally of the modulo-N checker.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/modulo_n_checker.sv
// Passive monitor checking that a sampled counter follows 0..N-1,0,...
// Define MODN_HOLD_CHECK_EN to also flag changes of cnt while ce=0 in LOCK.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | no valid previous sample; waiting for an in-range value
// ACQ     | tracking, counting consecutive correct transitions
// LOCK    | sequence tracked; mismatches raise err, N-1 -> 0 raises wrap
module modulo_n_checker
    import modulo_n_pkg::*;
#(
    parameter int unsigned N        = 10,
    parameter int unsigned WIDTH    = $clog2(N),
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] cnt,
    output logic             locked,
    output logic             wrap,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned GW = $clog2(LOCK_LEN + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d;
    logic             locked_q, locked_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] exp_v;
    logic [GW-1:0]    good_inc;
    logic             in_range;
    logic             hit;

    assign exp_v    = WIDTH'(mod_next(32'(prev_q), N));
    assign good_inc = good_q + 1'b1;
    assign in_range = (32'(cnt) < N);
    assign hit      = (cnt == exp_v);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce && in_range) begin
                    prev_d  = cnt;
                    good_d  = '0;
                    state_d = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (ce) begin
                    if (!in_range) begin
                        state_d = ST_IDLE;
                    end else begin
                        prev_d = cnt;
                        if (hit) begin
                            good_d = good_inc;
                            if (good_inc == GW'(LOCK_LEN)) begin
                                state_d = ST_LOCK;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                end
            end
            ST_LOCK: begin
                if (ce) begin
                    if (!in_range) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (hit) begin
                        wrap_d = (prev_q == WIDTH'(N - 1));
                        prev_d = cnt;
                    end else begin
                        err_d   = 1'b1;
                        prev_d  = cnt;
                        good_d  = '0;
                        state_d = ST_ACQ;
                    end
                end
`ifdef MODN_HOLD_CHECK_EN
                // The counter already advanced on the last enabled edge, so cnt must show exp.
                else if (!hit) begin
                    err_d   = 1'b1;
                    prev_d  = cnt;
                    good_d  = '0;
                    state_d = ST_ACQ;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    // Counts on err_d so err_cnt moves on the same edge the err pulse appears.
    sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk(clk),
        .rst(rst),
        .inc(err_d),
        .cnt(err_cnt)
    );

    assign locked = locked_q;
    assign wrap   = wrap_q;
    assign err    = err_q;

endmodule

// File: tb/tb_modulo_n_checker.sv
// Self-checking bench for modulo_n_checker: directed scenarios plus random
// stimulus against a behavioural model; honours MODN_HOLD_CHECK_EN if defined.
module tb_modulo_n_checker;

    localparam int N        = 10;
    localparam int LOCK_LEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce  = 1'b0;
    logic [3:0] cnt = 4'd0;

    logic       locked, wrap, err;
    logic [7:0] err_cnt;
    logic       locked2, wrap2, err2;
    logic [1:0] err_cnt2;

    int total = 0;
    int bad   = 0;

    modulo_n_checker #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .ce(ce), .cnt(cnt),
        .locked(locked), .wrap(wrap), .err(err), .err_cnt(err_cnt)
    );

    modulo_n_checker #(.N(N), .LOCK_LEN(LOCK_LEN), .ERR_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .ce(ce), .cnt(cnt),
        .locked(locked2), .wrap(wrap2), .err(err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    // Behavioural model: last good value, length of the current run of correct steps.
    bit m_have   = 0;
    int m_prev   = 0;
    int m_run    = 0;
    bit m_locked = 0;
    bit m_wrap   = 0;
    bit m_err    = 0;
    int m_errs   = 0;

    function automatic int ref_next(input int p);
        if (p < N) return (p + 1) % N;
        return (p + 1) % 16;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_have = 0; m_prev = 0; m_run = 0;
            m_locked = 0; m_wrap = 0; m_err = 0; m_errs = 0;
        end else begin
            m_wrap = 0;
            m_err  = 0;
            if (ce) begin
                if (int'(cnt) >= N) begin
                    m_err = m_locked;
                    m_locked = 0; m_have = 0; m_run = 0;
                end else if (!m_have) begin
                    m_have = 1; m_prev = int'(cnt); m_run = 0;
                end else if (int'(cnt) == ref_next(m_prev)) begin
                    m_wrap = m_locked && (m_prev == N - 1);
                    m_run++;
                    if (m_run >= LOCK_LEN) m_locked = 1;
                    m_prev = int'(cnt);
                end else begin
                    m_err = m_locked;
                    m_locked = 0; m_run = 0; m_prev = int'(cnt);
                end
            end
`ifdef MODN_HOLD_CHECK_EN
            else if (m_locked && int'(cnt) != ref_next(m_prev)) begin
                m_err = 1; m_locked = 0; m_run = 0; m_prev = int'(cnt); m_have = 1;
            end
`endif
            if (m_err) m_errs++;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("locked",   int'(locked),   int'(m_locked));
        cmp("wrap",     int'(wrap),     int'(m_wrap));
        cmp("err",      int'(err),      int'(m_err));
        cmp("err_cnt",  int'(err_cnt),  (m_errs > 255) ? 255 : m_errs);
        cmp("locked2",  int'(locked2),  int'(m_locked));
        cmp("err_cnt2", int'(err_cnt2), (m_errs > 3) ? 3 : m_errs);
    end

    task automatic step(input logic c, input logic [3:0] v);
        ce  = c;
        cnt = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        cmp("rst_locked",  int'(locked),   0);
        cmp("rst_wrap",    int'(wrap),     0);
        cmp("rst_err",     int'(err),      0);
        cmp("rst_err_cnt", int'(err_cnt),  0);
        cmp("rst_err_cnt2", int'(err_cnt2), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int         ctr;
    logic       cv;
    logic [3:0] v;

    initial begin
        repeat (2) @(negedge clk);
        cmp("init_locked",  int'(locked),  0);
        cmp("init_err_cnt", int'(err_cnt), 0);
        rst = 1'b1;

        // Clean sequence 0..9,0,1
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i % 10));
            if (i == 2)  cmp("lock_at2",  int'(locked), 0);
            if (i == 3)  cmp("lock_at3",  int'(locked), 1);
            if (i == 9)  cmp("wrap_at9",  int'(wrap),   0);
            if (i == 10) cmp("wrap_at0",  int'(wrap),   1);
            if (i == 11) cmp("wrap_at1",  int'(wrap),   0);
        end

        // 2,3 then 5 where 4 expected; relock with 6,7,8
        step(1'b1, 4'd2);
        step(1'b1, 4'd3);
        step(1'b1, 4'd5);
        cmp("mis_err",     int'(err),     1);
        cmp("mis_err_cnt", int'(err_cnt), 1);
        cmp("mis_locked",  int'(locked),  0);
        step(1'b1, 4'd6);
        cmp("mis_err_gone", int'(err), 0);
        step(1'b1, 4'd7);
        cmp("relock_7", int'(locked), 0);
        step(1'b1, 4'd8);
        cmp("relock_8", int'(locked), 1);

        // ce pattern 1,0,0,1 with a counter that advances only on ce
        step(1'b1, 4'd9);
        step(1'b0, 4'd0);
        step(1'b0, 4'd0);
        cmp("hold_locked", int'(locked), 1);
        step(1'b1, 4'd0);
        cmp("hold_wrap", int'(wrap), 1);
        cmp("hold_err",  int'(err),  0);

        // Out of range while locked, then again in IDLE
        step(1'b1, 4'd12);
        cmp("oor_err",    int'(err),    1);
        cmp("oor_locked", int'(locked), 0);
        step(1'b1, 4'd13);
        cmp("oor_idle_err", int'(err),     0);
        cmp("oor_err_cnt",  int'(err_cnt), 2);

        // Two more lock-then-error cycles: 2-bit tally saturates
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 4'(i));
            cmp("cyc_locked", int'(locked), 1);
            step(1'b1, 4'd7);
            cmp("cyc_err", int'(err), 1);
        end
        cmp("sat_err_cnt8", int'(err_cnt),  4);
        cmp("sat_err_cnt2", int'(err_cnt2), 3);

        // Lock, then asynchronous reset between edges
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i));
        cmp("pre_rst_locked", int'(locked), 1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(i));
            if (i == 2) cmp("post_rst_2", int'(locked), 0);
            if (i == 3) cmp("post_rst_3", int'(locked), 1);
        end

`ifdef MODN_HOLD_CHECK_EN
        step(1'b0, 4'd4);
        cmp("hc_ok", int'(err), 0);
        step(1'b0, 4'd6);
        cmp("hc_err", int'(err), 1);
`endif

        // Randomized: mostly a well-behaved counter with ce gaps, some glitches and resets
        ctr = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                ctr = 0;
            end
            cv = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'(ctr);
            step(cv, v);
            if (cv) ctr = (int'(v) < N) ? ((int'(v) + 1) % N) : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
